mdu_unit: RTL and testbench
===========================

# mdu_unit

Parametrised multiply/divide unit for the E stage of the pipelined MIPS core. It executes the MDU operations that the D-stage control decoder emits on its 4-bit MDU op field. It holds the architectural HI/LO registers and models multiply and divide latency with a busy counter. The hazard unit stalls D-stage MDU instructions while `start_o | busy_o` is high.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width.
- `MULT_CYCLES`, 5, busy cycles for mult/multu (and madd family); ≥1.
- `DIV_CYCLES`, 10, busy cycles for div/divu; ≥1.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `op_valid_i`  in  1  E-stage instruction is real (not bubble/flushed).
- `mdu_op_i`  in  4  op code from the control decoder.
- `rs_i`  in  WIDTH  forwarded rs value.
- `rt_i`  in  WIDTH  forwarded rt value.
- `start_o`  out  1  combinational; a mult/div op is accepted this cycle.
- `busy_o`  out  1  registered; an operation is in flight.
- `rd_data_o`  out  WIDTH  HI for op 5, LO for op 6, else 0; combinational.
- `hi_o`, `lo_o`  out  WIDTH  current HI/LO contents.

## Operation
- Op codes: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9–12 with madd feature; 13–15 treated as 0.
- Accept: `start_o = op_valid_i & (op ∈ {1..4, 9..12}) & !busy_o`.
- On accept:
  - Compute the full result from `rs_i`/`rt_i` into result registers.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Set busy.
- States: IDLE, BUSY.
  - IDLE→BUSY on accept.
  - BUSY: counter decrements each edge. At the edge where counter==1, write result to HI/LO, clear busy, return to IDLE.
- mult/multu: {HI,LO} = 2·WIDTH product, signed/unsigned.
- div/divu: LO = quotient truncated toward zero, HI = remainder, sign of dividend.
- Divide by zero: HI = rs, LO = all ones (both signednesses).
- Signed overflow (most-negative ÷ −1): LO = most-negative, HI = 0.
- mthi/mtlo: when `op_valid_i` and not busy, write `rs_i` to HI/LO at the edge.
- mthi/mtlo or a new mult/div while busy: ignored. The hazard unit guarantees this does not happen.
- mfhi/mflo: `rd_data_o` reflects the register value before any same-edge update.
- Reset (any time, including mid-operation):
  - HI, LO, counter and result registers cleared to 0.
  - busy_o = 0, state IDLE.
  - In-flight result discarded.

## Timing
- Accept at edge E0 → `busy_o` high for exactly N cycles (E0+1 … E0+N). HI/LO carry the new value after edge E0+N; `busy_o` low in the same cycle.
- `start_o` is combinational in the accept cycle, so the hazard unit can stall a following mfhi/mflo in D with zero gap.
- mthi/mtlo: new value visible on `hi_o`/`lo_o`/`rd_data_o` one cycle after the write edge.
- Back-to-back: a new op may be accepted in the first cycle `busy_o` is low.

## Configuration
- `MDU_MADD_EN` defined:
  - Ops 9 madd, 10 maddu, 11 msub, 12 msubu are supported.
  - {HI,LO} ± product, with the accumulate sampled at completion, using MULT_CYCLES.
- `MDU_MADD_EN` undefined: ops 9–12 behave as op 0 (no accept, no state change).

## Structure
- Package `mdu_pkg`:
  - op code localparams (`MDU_NONE`…`MDU_MSUBU`),
  - default latency constants,
  - the state enum.
- Sub-module `mdu_arith`: combinational product/quotient/remainder with the divide-by-zero and overflow rules, parametrised by WIDTH. The top holds the FSM, counter and HI/LO registers.

## Test plan
- mult rs=0xFFFFFFFF, rt=2 → busy 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div rs=−7, rt=2 → busy 10 cycles; LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). div rs=0x80000000, rt=−1 → LO=0x80000000, HI=0.
- divu rs=5, rt=0 → HI=5, LO=0xFFFFFFFF.
- mthi 0x1234, then mfhi next cycle → `rd_data_o`=0x1234. mfhi in the same cycle as mthi → old HI.
- Accept mult, assert reset at busy cycle 3 → busy_o=0, HI=LO=0 next cycle. The result never appears.
- With `MDU_MADD_EN`: HI=0, LO=10, madd rs=3, rt=4 → LO=22 after 5 cycles. Without the macro: op 9 → `start_o`=0, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default latencies, FSM states.
// Optional madd/maddu/msub/msubu support is enabled by defining MDU_MADD_EN.
package mdu_pkg;

    localparam int unsigned MDU_OP_W = 4;

    localparam logic [MDU_OP_W-1:0] MDU_NONE  = 4'd0;
    localparam logic [MDU_OP_W-1:0] MDU_MULT  = 4'd1;
    localparam logic [MDU_OP_W-1:0] MDU_MULTU = 4'd2;
    localparam logic [MDU_OP_W-1:0] MDU_DIV   = 4'd3;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 4'd4;
    localparam logic [MDU_OP_W-1:0] MDU_MFHI  = 4'd5;
    localparam logic [MDU_OP_W-1:0] MDU_MFLO  = 4'd6;
    localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 4'd7;
    localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 4'd8;
    localparam logic [MDU_OP_W-1:0] MDU_MADD  = 4'd9;
    localparam logic [MDU_OP_W-1:0] MDU_MADDU = 4'd10;
    localparam logic [MDU_OP_W-1:0] MDU_MSUB  = 4'd11;
    localparam logic [MDU_OP_W-1:0] MDU_MSUBU = 4'd12;

    localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
    localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    // How the completed result is folded into {HI,LO}
    typedef enum logic [1:0] {
        MDU_ACC_NONE = 2'd0,
        MDU_ACC_ADD  = 2'd1,
        MDU_ACC_SUB  = 2'd2
    } mdu_acc_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath: 2*WIDTH product, quotient and remainder.
// Division works on magnitudes and re-applies signs, so truncation is toward zero
// and the remainder takes the dividend's sign.
module mdu_arith #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               signed_i,
    output logic [2*WIDTH-1:0] prod_o,
    output logic [WIDTH-1:0]   quo_o,
    output logic [WIDTH-1:0]   rem_o
);

    localparam int unsigned DW = 2 * WIDTH;

    logic               a_neg;
    logic               b_neg;
    logic [DW-1:0]      a_ext;
    logic [DW-1:0]      b_ext;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   b_div;
    logic [WIDTH-1:0]   uq;
    logic [WIDTH-1:0]   ur;
    logic [WIDTH-1:0]   most_neg;

    // Product and signed-magnitude division with zero-divisor and overflow rules
    always_comb begin
        a_neg    = signed_i & a_i[WIDTH-1];
        b_neg    = signed_i & b_i[WIDTH-1];
        a_ext    = {{WIDTH{a_neg}}, a_i};
        b_ext    = {{WIDTH{b_neg}}, b_i};
        prod_o   = a_ext * b_ext;
        a_mag    = a_neg ? -a_i : a_i;
        b_mag    = b_neg ? -b_i : b_i;
        b_div    = (b_mag == '0) ? WIDTH'(1) : b_mag;
        uq       = a_mag / b_div;
        ur       = a_mag % b_div;
        most_neg = {1'b1, {(WIDTH-1){1'b0}}};
        quo_o    = (a_neg ^ b_neg) ? -uq : uq;
        rem_o    = a_neg ? -ur : ur;
        if (b_i == '0) begin
            quo_o = '1;
            rem_o = a_i;
        end else if (signed_i && (a_i == most_neg) && (b_i == '1)) begin
            quo_o = most_neg;
            rem_o = '0;
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: HI/LO registers, busy-counter latency model, IDLE/BUSY FSM.
// Define MDU_MADD_EN to accept madd/maddu/msub/msubu (ops 9-12).
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_valid_i,
    input  logic [MDU_OP_W-1:0] mdu_op_i,
    input  logic [WIDTH-1:0]    rs_i,
    input  logic [WIDTH-1:0]    rt_i,
    output logic                start_o,
    output logic                busy_o,
    output logic [WIDTH-1:0]    rd_data_o,
    output logic [WIDTH-1:0]    hi_o,
    output logic [WIDTH-1:0]    lo_o
);

    localparam int unsigned DW         = 2 * WIDTH;
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state_q, state_d;
    mdu_acc_e         acc_q, acc_d, acc_sel;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [DW-1:0]    res_q, res_d;

    logic             is_mul, is_div, is_signed;
    logic [DW-1:0]    prod;
    logic [WIDTH-1:0] quo, rem;
    logic [DW-1:0]    hilo;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .a_i      (rs_i),
        .b_i      (rt_i),
        .signed_i (is_signed),
        .prod_o   (prod),
        .quo_o    (quo),
        .rem_o    (rem)
    );

    // Decode the op field into multiply/divide class, signedness and accumulate mode
    always_comb begin
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        acc_sel   = MDU_ACC_NONE;
        case (mdu_op_i)
            MDU_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
            MDU_MULTU: is_mul = 1'b1;
            MDU_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
            MDU_DIVU:  is_div = 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD:  begin is_mul = 1'b1; is_signed = 1'b1; acc_sel = MDU_ACC_ADD; end
            MDU_MADDU: begin is_mul = 1'b1; acc_sel = MDU_ACC_ADD; end
            MDU_MSUB:  begin is_mul = 1'b1; is_signed = 1'b1; acc_sel = MDU_ACC_SUB; end
            MDU_MSUBU: begin is_mul = 1'b1; acc_sel = MDU_ACC_SUB; end
`endif
            default: ;
        endcase
    end

    assign start_o = op_valid_i & (is_mul | is_div) & (state_q == MDU_IDLE);
    assign busy_o  = (state_q == MDU_BUSY);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign hilo    = {hi_q, lo_q};

    // mfhi/mflo read the pre-edge register contents
    always_comb begin
        rd_data_o = '0;
        if (mdu_op_i == MDU_MFHI) rd_data_o = hi_q;
        if (mdu_op_i == MDU_MFLO) rd_data_o = lo_q;
    end

    // Next-state: accept, countdown, completion write-back, mthi/mtlo
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        case (state_q)
            MDU_IDLE: begin
                if (start_o) begin
                    state_d = MDU_BUSY;
                    acc_d   = acc_sel;
                    cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    res_d   = is_div ? {rem, quo} : prod;
                end else if (op_valid_i && (mdu_op_i == MDU_MTHI)) begin
                    hi_d = rs_i;
                end else if (op_valid_i && (mdu_op_i == MDU_MTLO)) begin
                    lo_d = rs_i;
                end
            end
            MDU_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = MDU_IDLE;
                    case (acc_q)
                        MDU_ACC_ADD: {hi_d, lo_d} = hilo + res_q;
                        MDU_ACC_SUB: {hi_d, lo_d} = hilo - res_q;
                        default:     {hi_d, lo_d} = res_q;
                    endcase
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= MDU_IDLE;
            acc_q   <= MDU_ACC_NONE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Randomised self-checking bench for mdu_unit against an arithmetic reference model.
// Define MDU_MADD_EN to also exercise ops 9-12.
module tb_mdu_unit;

    localparam int unsigned W     = 32;
    localparam int unsigned N_MUL = 5;
    localparam int unsigned N_DIV = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          op_valid;
    logic [3:0]    mdu_op;
    logic [W-1:0]  rs, rt;
    logic          start_o, busy_o;
    logic [W-1:0]  rd_data_o, hi_o, lo_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] m_hi, m_lo;

    mdu_unit #(.WIDTH(W), .MULT_CYCLES(N_MUL), .DIV_CYCLES(N_DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid_i (op_valid),
        .mdu_op_i   (mdu_op),
        .rs_i       (rs),
        .rt_i       (rt),
        .start_o    (start_o),
        .busy_o     (busy_o),
        .rd_data_o  (rd_data_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: new {HI,LO} for a mult/div/madd-class op, from plain 64-bit arithmetic
    function automatic logic [63:0] model_op(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] hl);
        longint       sa, sb, q, r;
        logic [63:0]  ua, ub, sp, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        sp = 64'(sa * sb);
        up = ua * ub;
        case (op)
            4'd1: return sp;
            4'd2: return up;
            4'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            4'd9:  return hl + sp;
            4'd10: return hl + up;
            4'd11: return hl - sp;
            4'd12: return hl - up;
            default: return hl;
        endcase
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one mult/div-class op at the current negedge; returns at the negedge where busy drops
    task automatic do_muldiv(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int          n;
        int          exp_n;
        exp   = model_op(op, a, b, {m_hi, m_lo});
        exp_n = (op == 4'd3 || op == 4'd4) ? N_DIV : N_MUL;
        op_valid = 1'b1; mdu_op = op; rs = a; rt = b;
        #1;
        check_eq($sformatf("start op%0d", op), 64'(start_o), 64'd1);
        @(negedge clk);
        op_valid = 1'b0; mdu_op = 4'd0;
        n = 0;
        while (busy_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        check_eq($sformatf("busy cycles op%0d", op), 64'(n), 64'(exp_n));
        check_eq($sformatf("hi op%0d a=%h b=%h", op, a, b), 64'(hi_o), 64'(exp[63:32]));
        check_eq($sformatf("lo op%0d a=%h b=%h", op, a, b), 64'(lo_o), 64'(exp[31:0]));
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    task automatic do_move(input logic to_hi, input logic [31:0] v);
        op_valid = 1'b1; mdu_op = to_hi ? 4'd7 : 4'd8; rs = v;
        #1;
        check_eq("mthi/mtlo no start", 64'(start_o), 64'd0);
        check_eq("hi before write edge", 64'(hi_o), 64'(m_hi));
        @(negedge clk);
        op_valid = 1'b0; mdu_op = 4'd0;
        if (to_hi) m_hi = v; else m_lo = v;
        check_eq("hi after move", 64'(hi_o), 64'(m_hi));
        check_eq("lo after move", 64'(lo_o), 64'(m_lo));
    endtask

    task automatic do_read(input logic from_hi);
        op_valid = 1'b1; mdu_op = from_hi ? 4'd5 : 4'd6;
        #1;
        check_eq(from_hi ? "mfhi data" : "mflo data", 64'(rd_data_o), 64'(from_hi ? m_hi : m_lo));
        @(negedge clk);
        op_valid = 1'b0; mdu_op = 4'd0;
    endtask

    // Op that must not start anything or disturb HI/LO
    task automatic do_inert(input logic [3:0] op, input logic valid);
        op_valid = valid; mdu_op = op; rs = $urandom; rt = $urandom;
        #1;
        check_eq($sformatf("no start op%0d v%0d", op, valid), 64'(start_o), 64'd0);
        @(negedge clk);
        op_valid = 1'b0; mdu_op = 4'd0;
        check_eq($sformatf("no busy op%0d", op), 64'(busy_o), 64'd0);
        check_eq($sformatf("hi kept op%0d", op), 64'(hi_o), 64'(m_hi));
        check_eq($sformatf("lo kept op%0d", op), 64'(lo_o), 64'(m_lo));
    endtask

    initial begin
        int  kind;
        logic [3:0] op;
        reset = 1'b0; op_valid = 1'b0; mdu_op = 4'd0; rs = '0; rt = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(negedge clk);
        check_eq("reset busy", 64'(busy_o), 64'd0);
        check_eq("reset hi", 64'(hi_o), 64'd0);
        check_eq("reset lo", 64'(lo_o), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed cases
        do_muldiv(4'd1, 32'hFFFF_FFFF, 32'd2);
        check_eq("mult hi const", 64'(hi_o), 64'hFFFF_FFFF);
        check_eq("mult lo const", 64'(lo_o), 64'hFFFF_FFFE);
        do_muldiv(4'd2, 32'hFFFF_FFFF, 32'd2);   // back-to-back in first non-busy cycle
        check_eq("multu hi const", 64'(hi_o), 64'h1);
        do_muldiv(4'd3, 32'hFFFF_FFF9, 32'd2);
        check_eq("div lo const", 64'(lo_o), 64'hFFFF_FFFD);
        check_eq("div hi const", 64'(hi_o), 64'hFFFF_FFFF);
        do_muldiv(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check_eq("div ovf lo", 64'(lo_o), 64'h8000_0000);
        check_eq("div ovf hi", 64'(hi_o), 64'h0);
        do_muldiv(4'd4, 32'd5, 32'd0);
        check_eq("divu by0 hi", 64'(hi_o), 64'd5);
        check_eq("divu by0 lo", 64'(lo_o), 64'hFFFF_FFFF);
        do_muldiv(4'd3, 32'hFFFF_FFF9, 32'd0);
        do_move(1'b1, 32'h1234);
        do_read(1'b1);
        check_eq("mfhi 0x1234", 64'(m_hi), 64'h1234);
        do_read(1'b0);

        // Ops that must be ignored
        do_inert(4'd1, 1'b0);
        do_inert(4'd13, 1'b1);
        do_inert(4'd15, 1'b1);
`ifndef MDU_MADD_EN
        do_inert(4'd9, 1'b1);
        do_inert(4'd12, 1'b1);
`else
        do_move(1'b1, 32'd0);
        do_move(1'b0, 32'd10);
        do_muldiv(4'd9, 32'd3, 32'd4);
        check_eq("madd lo 22", 64'(lo_o), 64'd22);
`endif

        // Randomised mix
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 5);
            if (kind <= 3) begin
`ifdef MDU_MADD_EN
                op = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(9, 12));
`else
                op = 4'($urandom_range(1, 4));
`endif
                do_muldiv(op, rand_operand(), rand_operand());
            end else if (kind == 4) begin
                do_move($urandom_range(0, 1) == 1, rand_operand());
            end else begin
                do_read($urandom_range(0, 1) == 1);
            end
        end

        // Reset in the third busy cycle discards the in-flight result
        do_move(1'b1, 32'hDEAD_0001);
        op_valid = 1'b1; mdu_op = 4'd1; rs = 32'h0001_0000; rt = 32'h0001_0000;
        @(negedge clk);
        op_valid = 1'b0; mdu_op = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_hi = '0; m_lo = '0;
        check_eq("midop reset busy", 64'(busy_o), 64'd0);
        check_eq("midop reset hi", 64'(hi_o), 64'd0);
        check_eq("midop reset lo", 64'(lo_o), 64'd0);
        repeat (8) @(negedge clk);
        check_eq("discarded hi", 64'(hi_o), 64'd0);
        check_eq("discarded lo", 64'(lo_o), 64'd0);
        check_eq("discarded busy", 64'(busy_o), 64'd0);
        do_muldiv(4'd2, 32'd7, 32'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
